// File: rtl/smp_pkg.sv
// Shared definitions for the SMP accumulator machine: opcodes, sequencer
// state encodings, ALU select codes and the decoded control word.
package smp_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_MVAC = 4'h3;
  localparam logic [3:0] OP_MOVR = 4'h4;
  localparam logic [3:0] OP_JUMP = 4'h5;
  localparam logic [3:0] OP_JMPZ = 4'h6;
  localparam logic [3:0] OP_JPNZ = 4'h7;
  localparam logic [3:0] OP_ADD  = 4'h8;
  localparam logic [3:0] OP_SUB  = 4'h9;
  localparam logic [3:0] OP_INAC = 4'hA;
  localparam logic [3:0] OP_CLAC = 4'hB;
  localparam logic [3:0] OP_AND  = 4'hC;
  localparam logic [3:0] OP_OR   = 4'hD;
  localparam logic [3:0] OP_XOR  = 4'hE;
  localparam logic [3:0] OP_NOT  = 4'hF;

  localparam logic [6:0] ALU_HOLD = 7'h00;
  localparam logic [6:0] ALU_ADD  = 7'h01;
  localparam logic [6:0] ALU_SUB  = 7'h02;
  localparam logic [6:0] ALU_INC  = 7'h03;
  localparam logic [6:0] ALU_CLR  = 7'h04;
  localparam logic [6:0] ALU_AND  = 7'h05;
  localparam logic [6:0] ALU_OR   = 7'h06;
  localparam logic [6:0] ALU_XOR  = 7'h07;
  localparam logic [6:0] ALU_NOT  = 7'h08;
  localparam logic [6:0] ALU_PASS = 7'h09;

  // Encodings 29..31 are unused and recover to FETCH1.
  typedef enum logic [4:0] {
    FETCH1 = 5'd0, FETCH2, FETCH3, DECODE,
    LDAC1, LDAC2, LDAC3, LDAC4, LDAC5,
    STAC1, STAC2, STAC3, STAC4, STAC5,
    MVAC1, MOVR1,
    JUMP1, JUMP2, JUMP3,
    JMPK1, JMPK2,
    ADD1, SUB1, INAC1, CLAC1, AND1, OR1, XOR1, NOT1
  } state_t;

  typedef struct packed {
    logic       we;
    logic       MEMbus;
    logic       BUSmem;
    logic       ARload;
    logic       ARinc;
    logic       PCload;
    logic       PCinc;
    logic       PCbus;
    logic       DRload;
    logic       DRHbus;
    logic       DRLbus;
    logic       TRload;
    logic       TRbus;
    logic       IRload;
    logic       Rload;
    logic       Rbus;
    logic       ACload;
    logic       ACbus;
    logic       Zload;
    logic       done;
    logic [6:0] alus;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Moore decode of the sequencer state into the data-path control word.
module ctrl_decode
  import smp_pkg::*;
(
  input  state_t state,
  output ctrl_t  cw
);

  always_comb begin
    cw      = '0;
    cw.alus = ALU_HOLD;
    case (state)
      FETCH1: begin cw.PCbus = 1'b1; cw.ARload = 1'b1; end
      FETCH2: begin cw.MEMbus = 1'b1; cw.DRload = 1'b1; cw.PCinc = 1'b1; end
      FETCH3: begin cw.IRload = 1'b1; cw.PCbus = 1'b1; cw.ARload = 1'b1; end
      // Address operand fetch is shared by LDAC and STAC: low byte, then high.
      LDAC1, STAC1: begin
        cw.MEMbus = 1'b1; cw.DRload = 1'b1; cw.PCinc = 1'b1; cw.ARinc = 1'b1;
      end
      LDAC2, STAC2: begin
        cw.TRload = 1'b1; cw.MEMbus = 1'b1; cw.DRload = 1'b1; cw.PCinc = 1'b1;
      end
      LDAC3, STAC3: begin cw.DRHbus = 1'b1; cw.TRbus = 1'b1; cw.ARload = 1'b1; end
      LDAC4: begin cw.MEMbus = 1'b1; cw.DRload = 1'b1; end
      LDAC5: begin
        cw.DRLbus = 1'b1; cw.ACload = 1'b1; cw.alus = ALU_PASS; cw.done = 1'b1;
      end
      STAC4: begin cw.ACbus = 1'b1; cw.DRload = 1'b1; end
      STAC5: begin
        cw.DRLbus = 1'b1; cw.BUSmem = 1'b1; cw.we = 1'b1; cw.done = 1'b1;
      end
      MVAC1: begin cw.ACbus = 1'b1; cw.Rload = 1'b1; cw.done = 1'b1; end
      MOVR1: begin
        cw.Rbus = 1'b1; cw.ACload = 1'b1; cw.alus = ALU_PASS; cw.done = 1'b1;
      end
      JUMP1: begin cw.MEMbus = 1'b1; cw.DRload = 1'b1; cw.ARinc = 1'b1; end
      JUMP2: begin cw.TRload = 1'b1; cw.MEMbus = 1'b1; cw.DRload = 1'b1; end
      JUMP3: begin
        cw.DRHbus = 1'b1; cw.TRbus = 1'b1; cw.PCload = 1'b1; cw.done = 1'b1;
      end
      // Untaken branch skips the two address bytes.
      JMPK1: cw.PCinc = 1'b1;
      JMPK2: begin cw.PCinc = 1'b1; cw.done = 1'b1; end
      ADD1: begin cw.Rbus = 1'b1; cw.ACload = 1'b1; cw.alus = ALU_ADD; cw.done = 1'b1; end
      SUB1: begin cw.Rbus = 1'b1; cw.ACload = 1'b1; cw.alus = ALU_SUB; cw.done = 1'b1; end
      INAC1: begin cw.ACload = 1'b1; cw.alus = ALU_INC; cw.done = 1'b1; end
      CLAC1: begin cw.ACload = 1'b1; cw.alus = ALU_CLR; cw.done = 1'b1; end
      AND1: begin cw.Rbus = 1'b1; cw.ACload = 1'b1; cw.alus = ALU_AND; cw.done = 1'b1; end
      OR1:  begin cw.Rbus = 1'b1; cw.ACload = 1'b1; cw.alus = ALU_OR;  cw.done = 1'b1; end
      XOR1: begin cw.Rbus = 1'b1; cw.ACload = 1'b1; cw.alus = ALU_XOR; cw.done = 1'b1; end
      NOT1: begin cw.ACload = 1'b1; cw.alus = ALU_NOT; cw.done = 1'b1; end
      default: ;
    endcase
    cw.Zload = cw.ACload;
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the SMP data path: state register and
// next-state logic here, control word decode in ctrl_decode.
module control_unit
  import smp_pkg::*;
#(
  parameter int ALUS_W = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [15:0]       IRout,
  input  logic              z,
  output logic              we,
  output logic              MEMbus,
  output logic              BUSmem,
  output logic              ARload,
  output logic              ARinc,
  output logic              PCload,
  output logic              PCinc,
  output logic              PCbus,
  output logic              DRload,
  output logic              DRHbus,
  output logic              DRLbus,
  output logic              TRload,
  output logic              TRbus,
  output logic              IRload,
  output logic              Rload,
  output logic              Rbus,
  output logic              ACload,
  output logic              ACbus,
  output logic              Zload,
  output logic [ALUS_W-1:0] ALUS,
  output logic [4:0]        state,
  output logic              instr_done
);

  state_t     st;
  ctrl_t      cw;
  logic [3:0] opcode;
  logic       unused_ir;

  assign opcode    = IRout[3:0];
  assign unused_ir = ^IRout[15:4];

  always_ff @(posedge clock) begin
    if (!reset_n) st <= FETCH1;
    else begin
      case (st)
        FETCH1: st <= FETCH2;
        FETCH2: st <= FETCH3;
        FETCH3: st <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LDAC: st <= LDAC1;
            OP_STAC: st <= STAC1;
            OP_MVAC: st <= MVAC1;
            OP_MOVR: st <= MOVR1;
            OP_JUMP: st <= JUMP1;
            OP_JMPZ: st <= z ? JUMP1 : JMPK1;
            OP_JPNZ: st <= z ? JMPK1 : JUMP1;
            OP_ADD:  st <= ADD1;
            OP_SUB:  st <= SUB1;
            OP_INAC: st <= INAC1;
            OP_CLAC: st <= CLAC1;
            OP_AND:  st <= AND1;
            OP_OR:   st <= OR1;
            OP_XOR:  st <= XOR1;
            OP_NOT:  st <= NOT1;
            default: st <= FETCH1;
          endcase
        end
        LDAC1: st <= LDAC2;
        LDAC2: st <= LDAC3;
        LDAC3: st <= LDAC4;
        LDAC4: st <= LDAC5;
        STAC1: st <= STAC2;
        STAC2: st <= STAC3;
        STAC3: st <= STAC4;
        STAC4: st <= STAC5;
        JUMP1: st <= JUMP2;
        JUMP2: st <= JUMP3;
        JMPK1: st <= JMPK2;
        // Final execute states and stray encodings all return to fetch.
        default: st <= FETCH1;
      endcase
    end
  end

  ctrl_decode u_decode (
    .state (st),
    .cw    (cw)
  );

  assign we         = cw.we;
  assign MEMbus     = cw.MEMbus;
  assign BUSmem     = cw.BUSmem;
  assign ARload     = cw.ARload;
  assign ARinc      = cw.ARinc;
  assign PCload     = cw.PCload;
  assign PCinc      = cw.PCinc;
  assign PCbus      = cw.PCbus;
  assign DRload     = cw.DRload;
  assign DRHbus     = cw.DRHbus;
  assign DRLbus     = cw.DRLbus;
  assign TRload     = cw.TRload;
  assign TRbus      = cw.TRbus;
  assign IRload     = cw.IRload;
  assign Rload      = cw.Rload;
  assign Rbus       = cw.Rbus;
  assign ACload     = cw.ACload;
  assign ACbus      = cw.ACbus;
  assign Zload      = cw.Zload;
  assign ALUS       = ALUS_W'(cw.alus);
  assign state      = st;
  // NOP completes in DECODE itself, so its done flag depends on the opcode.
  assign instr_done = cw.done | ((st == DECODE) && (opcode == OP_NOP));

endmodule
